// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 device-to-host receive path:
//   - frame FSM state encoding (IDLE / DATA / PARITY / STOP)
//   - PS/2 framing constants and well-known scan code prefixes
//   - default conditioning / timeout parameters
//   - frame evaluation result type and odd-parity helper
// -----------------------------------------------------------------------------
package ps2_pkg;

    // Frame FSM state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // PS/2 framing constants.
    localparam logic       PS2_START_BIT   = 1'b0;
    localparam logic       PS2_STOP_BIT    = 1'b1;
    localparam logic [7:0] PS2_BREAK_CODE  = 8'hF0;
    localparam logic [7:0] PS2_EXTEND_CODE = 8'hE0;

    // Defaults: 8-sample glitch filter, 1 ms inter-bit timeout at 50 MHz.
    localparam int DEFAULT_FILTER_LEN     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

    // Outcome of evaluating a complete frame in the STOP strobe cycle.
    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_KEY    = 2'd1,
        RES_PARITY = 2'd2,
        RES_FRAME  = 2'd3
    } frame_result_e;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// -----------------------------------------------------------------------------
// ps2_input_filter
// Conditions the raw, asynchronous PS/2 pins for the frame FSM.
//   - 2-flop synchronizers on ps2_clk and ps2_dat (reset to 1, the idle bus)
//   - glitch filter: the filtered clock only follows the synchronized clock
//     after FILTER_LEN consecutive samples that differ from its current level
//   - bit_strobe: one-cycle pulse on each 1->0 change of the filtered clock
//
// Ports:
//   clock       in   system clock
//   resetn      in   asynchronous active-low reset
//   ps2_clk     in   raw PS/2 clock pin
//   ps2_dat     in   raw PS/2 data pin
//   bit_strobe  out  one-cycle pulse, a PS/2 bit is to be sampled now
//   dat_sync    out  synchronized PS/2 data, valid to sample with bit_strobe
// -----------------------------------------------------------------------------
module ps2_input_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic clock,
    input  logic resetn,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic bit_strobe,
    output logic dat_sync
);

    logic       clk_meta;
    logic       clk_sync;
    logic       dat_meta;
    logic       filt_clk;
    logic [7:0] filt_cnt;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of its neighbours (shift behaviour).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    // filt_cnt counts consecutive synchronized samples that disagree with
    // filt_clk; any agreeing sample restarts the count, so short glitches die.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            filt_clk   <= 1'b1;
            filt_cnt   <= 8'd0;
            bit_strobe <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            if (clk_sync == filt_clk) begin
                filt_cnt <= 8'd0;
            end else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
                filt_clk   <= clk_sync;
                filt_cnt   <= 8'd0;
                // Only a high-to-low change of the filtered clock is a bit edge.
                bit_strobe <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// -----------------------------------------------------------------------------
// ps2_scancode_rx
// PS/2 device-to-host frame receiver. Checks start, odd parity and stop bits,
// publishes the newest scan code together with the previous one and pulses a
// strobe for every accepted byte or dropped frame. A frame whose bits stop
// arriving for TIMEOUT_CYCLES system clocks is aborted with frame_error.
//
// Ports:
//   clock                  in   system clock, rising edge
//   resetn                 in   asynchronous active-low reset
//   ps2_clk                in   raw PS/2 clock pin (never driven here)
//   ps2_dat                in   raw PS/2 data pin (never driven here)
//   ps2_key_received       out  most recent accepted scan code
//   ps2_last_key_received  out  scan code accepted before ps2_key_received
//   key_valid              out  one-cycle pulse per accepted byte
//   parity_error           out  one-cycle pulse, frame dropped on bad parity
//   frame_error            out  one-cycle pulse, bad stop bit or timeout
// -----------------------------------------------------------------------------
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ps2_key_received,
    output logic [7:0] ps2_last_key_received,
    output logic       key_valid,
    output logic       parity_error,
    output logic       frame_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic             bit_strobe;
    logic             dat_sync;
    logic [1:0]       state;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_cnt;
    logic             parity_bit;
    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout_hit;
    frame_result_e    frame_res;

    ps2_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clock      (clock),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .bit_strobe (bit_strobe),
        .dat_sync   (dat_sync)
    );

    // The timeout fires on the edge where the counter would reach
    // TIMEOUT_CYCLES-1, i.e. TIMEOUT_CYCLES-1 clocks after the edge that
    // consumed the last strobe. The registered frame_error lands on that edge.
    assign timeout_hit = (state != ST_IDLE) &&
                         (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 2));

    // Verdict on the frame being closed by the current (STOP) strobe; only
    // used when state is STOP and a strobe is present.
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it holding its old value (which would infer a latch).
    always_comb begin
        frame_res = RES_NONE;
        if (!odd_parity_ok(shift_reg, parity_bit)) begin
            frame_res = RES_PARITY;
        end else if (dat_sync == PS2_STOP_BIT) begin
            frame_res = RES_KEY;
        end else begin
            frame_res = RES_FRAME;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state                 <= ST_IDLE;
            shift_reg             <= 8'd0;
            bit_cnt               <= 3'd0;
            parity_bit            <= 1'b0;
            timeout_cnt           <= '0;
            ps2_key_received      <= 8'd0;
            ps2_last_key_received <= 8'd0;
            key_valid             <= 1'b0;
            parity_error          <= 1'b0;
            frame_error           <= 1'b0;
        end else begin
            key_valid    <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;

            if (timeout_hit) begin
                // Abort wins over a strobe arriving in the same cycle.
                frame_error <= 1'b1;
                state       <= ST_IDLE;
                shift_reg   <= 8'd0;
                bit_cnt     <= 3'd0;
                timeout_cnt <= '0;
            end else if (bit_strobe) begin
                timeout_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        // A 1 here is a spurious start: silently stay idle.
                        if (dat_sync == PS2_START_BIT) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        // LSB first: the first data bit ends up in bit 0.
                        shift_reg <= {dat_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_bit <= dat_sync;
                        state      <= ST_STOP;
                    end
                    ST_STOP: begin
                        state   <= ST_IDLE;
                        bit_cnt <= 3'd0;
                        case (frame_res)
                            RES_KEY: begin
                                ps2_last_key_received <= ps2_key_received;
                                ps2_key_received      <= shift_reg;
                                key_valid             <= 1'b1;
                            end
                            RES_PARITY: parity_error <= 1'b1;
                            RES_FRAME:  frame_error  <= 1'b1;
                            default:    ;
                        endcase
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state == ST_IDLE) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_scancode_rx
// Self-checking bench for ps2_scancode_rx. A PS/2 device model sends frames;
// the expected outcome of each frame is pushed to a scoreboard queue and is
// popped and compared whenever the DUT pulses key_valid/parity_error/
// frame_error. The PS/2 bit period is scaled down (80 system clocks) and the
// timeout shortened so the run stays short.
// -----------------------------------------------------------------------------
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int FILT = 8;
    localparam int TMO  = 300;
    localparam int HALF = 40;

    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_PERR  = 2;
    localparam int K_FERR  = 3;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] ps2_key_received;
    logic [7:0] ps2_last_key_received;
    logic       key_valid;
    logic       parity_error;
    logic       frame_error;

    ps2_scancode_rx #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock                 (clock),
        .resetn                (resetn),
        .ps2_clk               (ps2_clk),
        .ps2_dat               (ps2_dat),
        .ps2_key_received      (ps2_key_received),
        .ps2_last_key_received (ps2_last_key_received),
        .key_valid             (key_valid),
        .parity_error          (parity_error),
        .frame_error           (frame_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        bit         par_good;
        bit         stop;
        int         kind;
        logic [7:0] key;
        logic [7:0] last;
    } vec_t;

    typedef struct {
        int         kind;
        logic [7:0] key;
        logic [7:0] last;
        bit         timed;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_strobe_cyc = 0;
    int   strobe_cnt = 0;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(posedge clock) cyc++;

    // Scoreboard consumer: compare every output pulse against the queue head.
    always @(negedge clock) begin
        int   n;
        int   kind;
        exp_t e;
        if (resetn) begin
            n = int'(key_valid) + int'(parity_error) + int'(frame_error);
            kind = key_valid ? K_VALID : parity_error ? K_PERR : frame_error ? K_FERR : K_NONE;
            if (n != 0) begin
                check("pulse_onehot", n, 1);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", kind, K_NONE);
                end else begin
                    e = sb.pop_front();
                    check("result_kind", kind, e.kind);
                    check("key_received", int'(ps2_key_received), int'(e.key));
                    check("last_key_received", int'(ps2_last_key_received), int'(e.last));
                    // Strobe seen in cycle c is consumed at the next edge; the
                    // timeout pulse follows TMO-1 clocks after that edge.
                    if (e.timed)
                        check("timeout_latency", cyc - last_strobe_cyc, TMO);
                end
            end
        end
        if (dut.u_filter.bit_strobe) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
        end
    end

    task automatic push_exp(input int kind, input logic [7:0] key, input logic [7:0] last,
                            input bit timed);
        exp_t e;
        e.kind = kind; e.key = key; e.last = last; e.timed = timed;
        sb.push_back(e);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clock);
        ps2_dat = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    // Send the first nbits of an 11-bit frame (start, 8 data LSB first, parity, stop).
    task automatic send_bits(input logic [7:0] data, input bit par_good, input bit stop,
                             input int nbits);
        logic [10:0] frame;
        logic        par;
        par   = par_good ? ~^data : ^data;
        frame = {stop, par, data, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(frame[i]);
        @(negedge clock);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    vec_t vecs[9];

    initial begin
        int s0;

        //          data   par  stop kind     key    last
        vecs[0] = '{8'h1C, 1'b1, 1'b1, K_VALID, 8'h1C, 8'h00};
        vecs[1] = '{8'hF0, 1'b1, 1'b1, K_VALID, 8'hF0, 8'h1C};
        vecs[2] = '{8'h1C, 1'b1, 1'b1, K_VALID, 8'h1C, 8'hF0};
        vecs[3] = '{8'h1C, 1'b0, 1'b1, K_PERR,  8'h1C, 8'hF0};
        vecs[4] = '{8'h29, 1'b1, 1'b1, K_VALID, 8'h29, 8'h1C};
        vecs[5] = '{8'h5A, 1'b1, 1'b0, K_FERR,  8'h29, 8'h1C};
        vecs[6] = '{8'h29, 1'b1, 1'b1, K_VALID, 8'h29, 8'h29};
        vecs[7] = '{8'h00, 1'b1, 1'b1, K_VALID, 8'h00, 8'h29};
        vecs[8] = '{8'hFF, 1'b1, 1'b1, K_VALID, 8'hFF, 8'h00};

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_key", int'(ps2_key_received), 0);
        check("rst_last", int'(ps2_last_key_received), 0);
        check("rst_valid", int'(key_valid), 0);
        check("rst_perr", int'(parity_error), 0);
        check("rst_ferr", int'(frame_error), 0);
        resetn = 1'b1;
        repeat (20) @(negedge clock);

        // Table-driven frames.
        for (int i = 0; i < 9; i++) begin
            push_exp(vecs[i].kind, vecs[i].key, vecs[i].last, 1'b0);
            send_bits(vecs[i].data, vecs[i].par_good, vecs[i].stop, 11);
            wait_drain(200);
        end

        // Glitch: 3-clock low pulse while idle must not produce a strobe.
        s0 = strobe_cnt;
        @(negedge clock);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clock);
        check("glitch_no_strobe", strobe_cnt, s0);
        check("glitch_state_idle", int'(dut.state), int'(ST_IDLE));

        // Timeout after start + 4 data bits, then a clean 0x5A.
        push_exp(K_FERR, 8'hFF, 8'h00, 1'b1);
        send_bits(8'h5A, 1'b1, 1'b1, 5);
        wait_drain(TMO + 100);
        check("timeout_state_idle", int'(dut.state), int'(ST_IDLE));
        push_exp(K_VALID, 8'h5A, 8'hFF, 1'b0);
        send_bits(8'h5A, 1'b1, 1'b1, 11);
        wait_drain(200);

        // Reset after start + 5 data bits, then a clean 0x1C.
        send_bits(8'h33, 1'b1, 1'b1, 6);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midrst_key", int'(ps2_key_received), 0);
        check("midrst_last", int'(ps2_last_key_received), 0);
        check("midrst_pulses", int'({key_valid, parity_error, frame_error}), 0);
        repeat (5) @(negedge clock);
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        push_exp(K_VALID, 8'h1C, 8'h00, 1'b0);
        send_bits(8'h1C, 1'b1, 1'b1, 11);
        wait_drain(200);

        // Quiet period: any stray pulse is flagged by the scoreboard consumer.
        repeat (TMO + 50) @(negedge clock);
        check("final_key", int'(ps2_key_received), 8'h1C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
